// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared constants, parser state encoding and decoded-byte record for the key tracker
package kb_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Prefix parser states; EXT/EXT_BRK are only reachable with extended-prefix support built in
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_t;

  // One decoded scan-code event: a make or break of a (possibly extended) code
  typedef struct packed {
    logic       valid;
    logic       is_break;
    logic       is_ext;
    logic [7:0] code;
  } kb_rec_t;

  function automatic kb_rec_t make_rec(input logic is_break, input logic is_ext, input logic [7:0] code);
    kb_rec_t r;
    r.valid    = 1'b1;
    r.is_break = is_break;
    r.is_ext   = is_ext;
    r.code     = code;
    return r;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [3:0] lowest_index(input logic [15:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kb_scan_parser.sv
// rtl/kb_scan_parser.sv - PS/2 break/extended prefix FSM; KB_EXT_PREFIX_EN enables the 0xE0 prefix states
module kb_scan_parser
  import kb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  input  logic       clr,
  output kb_rec_t    rec
);

  kb_state_t state;

  // Prefix state machine with the decoded record registered one cycle after the byte strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rec   <= '0;
    end else if (clr) begin
      // clr also kills any record still in flight so no stale event reaches the tracker
      state <= ST_IDLE;
      rec   <= '0;
    end else begin
      rec <= '0;
      if (scan_done_tick) begin
        case (state)
          ST_IDLE: begin
            if (scan_code == BREAK_CODE) begin
              state <= ST_BRK;
`ifdef KB_EXT_PREFIX_EN
            end else if (scan_code == EXT_CODE) begin
              state <= ST_EXT;
`endif
            end else begin
              rec   <= make_rec(1'b0, 1'b0, scan_code);
              state <= ST_IDLE;
            end
          end
`ifdef KB_EXT_PREFIX_EN
          ST_EXT: begin
            if (scan_code == BREAK_CODE) begin
              state <= ST_EXT_BRK;
            end else if (scan_code == EXT_CODE) begin
              state <= ST_EXT;
            end else begin
              rec   <= make_rec(1'b0, 1'b1, scan_code);
              state <= ST_IDLE;
            end
          end
          ST_EXT_BRK: begin
            // A second prefix here is malformed; drop it and resynchronise
            if (scan_code != BREAK_CODE && scan_code != EXT_CODE) begin
              rec <= make_rec(1'b1, 1'b1, scan_code);
            end
            state <= ST_IDLE;
          end
`endif
          ST_BRK: begin
`ifdef KB_EXT_PREFIX_EN
            if (scan_code != BREAK_CODE && scan_code != EXT_CODE) begin
`else
            if (scan_code != BREAK_CODE) begin
`endif
              rec <= make_rec(1'b1, 1'b0, scan_code);
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/kb_multi_key_tracker.sv
// rtl/kb_multi_key_tracker.sv - held-state and press/release events for programmed keys; KB_EXT_PREFIX_EN honours key_ext
module kb_multi_key_tracker
  import kb_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_done_tick,
  input  logic [7:0]            scan_code,
  input  logic [NUM_KEYS*8-1:0] key_codes,
  input  logic [NUM_KEYS-1:0]   key_ext,
  input  logic                  clr,
  output logic [NUM_KEYS-1:0]   key_down,
  output logic                  any_down,
  output logic                  press_tick,
  output logic                  release_tick,
  output logic [IDX_W-1:0]      event_idx
);

  kb_rec_t             rec;
  logic [NUM_KEYS-1:0] match;
  logic [NUM_KEYS-1:0] hit;
  logic [15:0]         hit_pad;
  logic [3:0]          low_idx;

  kb_scan_parser u_parser (
    .clk            (clk),
    .rst            (reset),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .clr            (clr),
    .rec            (rec)
  );

`ifndef KB_EXT_PREFIX_EN
  // Without prefix support the extension bits carry no meaning
  logic unused_ext;
  assign unused_ext = ^{key_ext, rec.is_ext};
`endif

  // Compare the decoded code against every programmed key
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
`ifdef KB_EXT_PREFIX_EN
      match[i] = (key_codes[8*i +: 8] == rec.code) && (key_ext[i] == rec.is_ext);
`else
      match[i] = (key_codes[8*i +: 8] == rec.code);
`endif
    end
  end

  // Keys that actually change: makes only affect released keys, breaks only held ones
  always_comb begin
    hit = '0;
    if (rec.valid) begin
      hit = rec.is_break ? (match & key_down) : (match & ~key_down);
    end
    hit_pad                = '0;
    hit_pad[NUM_KEYS-1:0]  = hit;
    low_idx                = lowest_index(hit_pad);
  end

  // Held-key state, summary flag and one-cycle event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_down     <= '0;
      any_down     <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      event_idx    <= '0;
    end else begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      if (clr) begin
        key_down <= '0;
        any_down <= 1'b0;
      end else if (|hit) begin
        if (rec.is_break) begin
          key_down     <= key_down & ~hit;
          any_down     <= |(key_down & ~hit);
          release_tick <= 1'b1;
        end else begin
          key_down   <= key_down | hit;
          any_down   <= 1'b1;
          press_tick <= 1'b1;
        end
        event_idx <= low_idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_kb_multi_key_tracker.sv
// tb/tb_kb_multi_key_tracker.sv - scoreboard bench for kb_multi_key_tracker (either KB_EXT_PREFIX_EN build)
module tb_kb_multi_key_tracker;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_done_tick;
  logic [7:0]  scan_code;
  logic [31:0] key_codes;
  logic [3:0]  key_ext;
  logic        clr;
  logic [3:0]  key_down;
  logic        any_down;
  logic        press_tick;
  logic        release_tick;
  logic [1:0]  event_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rel;
    logic [1:0] idx;
    logic [3:0] kd;
  } ev_t;

  ev_t exp_q[$];

  kb_multi_key_tracker #(.NUM_KEYS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_done_tick (scan_done_tick),
    .scan_code      (scan_code),
    .key_codes      (key_codes),
    .key_ext        (key_ext),
    .clr            (clr),
    .key_down       (key_down),
    .any_down       (any_down),
    .press_tick     (press_tick),
    .release_tick   (release_tick),
    .event_idx      (event_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every event pulse must match the oldest expected event
  always @(negedge clk) begin
    if (!reset && (press_tick || release_tick)) begin
      ev_t e;
      check("tick_exclusive", 32'(press_tick & release_tick), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {24'd0, press_tick, release_tick, event_idx, key_down}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", 32'(release_tick), 32'(e.rel));
        check("event_idx", 32'(event_idx), 32'(e.idx));
        check("event_key_down", 32'(key_down), 32'(e.kd));
        check("event_any_down", 32'(any_down), 32'(|e.kd));
      end
    end
  end

  task automatic expect_ev(input logic rel, input logic [1:0] idx, input logic [3:0] kd);
    exp_q.push_back('{rel: rel, idx: idx, kd: kd});
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    scan_code      = b;
    scan_done_tick = 1'b1;
    @(posedge clk); #1;
    scan_done_tick = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    scan_done_tick = 1'b0;
    scan_code      = 8'h00;
    clr            = 1'b0;
    key_codes      = {8'h23, 8'h1B, 8'h1C, 8'h1D};
    key_ext        = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_key_down", 32'(key_down), 32'd0);
    check("reset_any_down", 32'(any_down), 32'd0);
    check("reset_ticks", {30'd0, press_tick, release_tick}, 32'd0);
    check("reset_event_idx", 32'(event_idx), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single press of key 1
    expect_ev(1'b0, 2'd1, 4'b0010);
    send(8'h1C);
    drain("t1_drain");
    check("t1_key_down", 32'(key_down), 32'h2);

    // Typematic repeats then a break
    send(8'h1C);
    send(8'h1C);
    expect_ev(1'b1, 2'd1, 4'b0000);
    send(8'hF0);
    send(8'h1C);
    drain("t2_drain");
    check("t2_key_down", 32'(key_down), 32'h0);

`ifdef KB_EXT_PREFIX_EN
    // Extended key 3
    key_codes[31:24] = 8'h75;
    key_ext          = 4'b1000;
    send(8'h75);
    drain("t3_plain_drain");
    check("t3_plain_ignored", 32'(key_down), 32'h0);
    expect_ev(1'b0, 2'd3, 4'b1000);
    send(8'hE0);
    send(8'h75);
    drain("t3_make_drain");
    send(8'hE0);
    send(8'h1C);
    drain("t3_ext_mismatch_drain");
    check("t3_ext_mismatch", 32'(key_down), 32'h8);
    expect_ev(1'b1, 2'd3, 4'b0000);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("t3_break_drain");
    key_codes[31:24] = 8'h23;
    key_ext          = 4'b0000;
`else
    // 0xE0 as an ordinary code; key_ext ignored
    key_codes[7:0] = 8'hE0;
    key_ext        = 4'b0001;
    expect_ev(1'b0, 2'd0, 4'b0001);
    send(8'hE0);
    drain("t6_make_drain");
    expect_ev(1'b1, 2'd0, 4'b0000);
    send(8'hF0);
    send(8'hE0);
    drain("t6_break_drain");
    check("t6_key_down", 32'(key_down), 32'h0);
    key_codes[7:0] = 8'h1D;
    key_ext        = 4'b0000;
`endif

    // Hold two keys, clear, then a break of an unheld key
    expect_ev(1'b0, 2'd0, 4'b0001);
    send(8'h1D);
    expect_ev(1'b0, 2'd2, 4'b0101);
    send(8'h1B);
    drain("t4_hold_drain");
    pulse_clr();
    check("t4_clr_key_down", 32'(key_down), 32'h0);
    check("t4_clr_any_down", 32'(any_down), 32'h0);
    send(8'hF0);
    send(8'h1D);
    drain("t4_unheld_drain");
    check("t4_unheld_key_down", 32'(key_down), 32'h0);

    // clr drops a pending break prefix
    send(8'hF0);
    pulse_clr();
    expect_ev(1'b0, 2'd0, 4'b0001);
    send(8'h1D);
    drain("t4_prefix_drain");
    pulse_clr();

    // Reset drops a pending break prefix
    send(8'hF0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("t5_reset_key_down", 32'(key_down), 32'h0);
    expect_ev(1'b0, 2'd0, 4'b0001);
    send(8'h1D);
    drain("t5_make_drain");
    expect_ev(1'b1, 2'd0, 4'b0000);
    send(8'hF0);
    send(8'h1D);
    drain("t5_break_drain");

    // Duplicate codes: both keys follow, lowest index reported
    key_codes[23:16] = 8'h1D;
    expect_ev(1'b0, 2'd0, 4'b0101);
    send(8'h1D);
    drain("dup_make_drain");
    expect_ev(1'b1, 2'd0, 4'b0000);
    send(8'hF0);
    send(8'h1D);
    drain("dup_break_drain");
    key_codes[23:16] = 8'h1B;

    // Reprogramming a held key keeps it held until the new code breaks
    expect_ev(1'b0, 2'd1, 4'b0010);
    send(8'h1C);
    drain("reprog_make_drain");
    key_codes[15:8] = 8'h2B;
    repeat (3) @(posedge clk);
    #1;
    check("reprog_still_held", 32'(key_down), 32'h2);
    send(8'hF0);
    send(8'h1C);
    drain("reprog_old_drain");
    check("reprog_old_ignored", 32'(key_down), 32'h2);
    expect_ev(1'b1, 2'd1, 4'b0000);
    send(8'hF0);
    send(8'h2B);
    drain("reprog_break_drain");
    check("reprog_released", 32'(key_down), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
